// File: rtl/mopshub_test_sequencer_if.sv
// Phase handshake between the test sequencer and the phase executor
// (data generator / emulator).
//   phase_req   : one-hot phase request, held high while the phase runs
//   phase_end   : one-hot end pulse from the executor
//   bus_id      : CAN bus currently under test
//   cur_phase   : phase index (0 trim, 1 rx, 2 tx, 3 custom)
//   endwait_all : single-cycle pulse after an RX phase completes normally
interface mopshub_test_sequencer_if;
  logic [3:0] phase_req;
  logic [3:0] phase_end;
  logic [4:0] bus_id;
  logic [1:0] cur_phase;
  logic       endwait_all;

  modport master (
    output phase_req, bus_id, cur_phase, endwait_all,
    input  phase_end
  );

  modport slave (
    input  phase_req, bus_id, cur_phase, endwait_all,
    output phase_end
  );
endinterface

// File: rtl/mopshub_test_sequencer.sv
// Test-phase sequencer for the MOPSHUB bench / BIST. Walks buses
// 0..n_buses-1 and on each bus runs the enabled phases in the order
// trim, rx, tx, custom, with a fixed idle gap between phases and a
// per-phase timeout.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start, abort        : run request (ignored while busy), run abort
//   n_buses, phase_mask : run configuration, latched on an accepted start
//   phs                 : phase handshake (master side)
//   busy, done          : not-idle flag, end-of-run pulse
//   timeout_err,err_cnt : sticky timeout flag and saturating timeout count
//
// state    | meaning
// IDLE     | waiting for start
// SELECT   | pick lowest enabled phase at or above the pointer
// REQ      | phase requested, waiting for end or timeout
// GAP      | idle gap before the next phase
// NEXT_BUS | advance to the next bus or finish
// DONE     | one-cycle done pulse
module mopshub_test_sequencer #(
  parameter int N_BUSES     = 32,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] n_buses,
  input  logic [3:0] phase_mask,
  mopshub_test_sequencer_if.master phs,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [7:0] err_cnt
);

  // One down-counter serves both the REQ timeout and the GAP length.
  localparam int TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_REQ, S_GAP, S_NEXT_BUS, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       mask_q;
  logic [4:0]       last_bus_q;
  logic [4:0]       bus_q;
  logic [2:0]       ptr_q;
  logic [1:0]       phase_q;
  logic [TMR_W-1:0] tmr_q;
  logic             ewa_q;

  logic [4:0] nb_clamp;
  logic [4:0] last_bus_d;
  logic       sel_found;
  logic [1:0] sel_phase;
  logic       end_hit;
  logic       tmr_zero;
  logic       start_acc;

  always_comb begin
    nb_clamp = (n_buses == 5'd0) ? 5'd1 : n_buses;
    if (int'(nb_clamp) > N_BUSES) nb_clamp = 5'(N_BUSES);
    last_bus_d = nb_clamp - 5'd1;
  end

  // Descending scan so the lowest qualifying phase is the one kept.
  always_comb begin
    sel_found = 1'b0;
    sel_phase = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(ptr_q))) begin
        sel_found = 1'b1;
        sel_phase = 2'(i);
      end
    end
  end

  assign end_hit   = phs.phase_end[phase_q];
  assign tmr_zero  = (tmr_q == '0);
  assign start_acc = (state_q == S_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (start_acc) state_d = (phase_mask == 4'd0) ? S_DONE : S_SELECT;
        S_SELECT:   state_d = sel_found ? S_REQ : S_NEXT_BUS;
        S_REQ:      if (end_hit || tmr_zero) state_d = S_GAP;
        S_GAP:      if (tmr_zero) state_d = S_SELECT;
        S_NEXT_BUS: state_d = (bus_q == last_bus_q) ? S_DONE : S_SELECT;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q      <= 4'd0;
      last_bus_q  <= 5'd0;
      bus_q       <= 5'd0;
      ptr_q       <= 3'd0;
      phase_q     <= 2'd0;
      tmr_q       <= '0;
      ewa_q       <= 1'b0;
      timeout_err <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      ewa_q <= 1'b0;
      if (start_acc) begin
        mask_q      <= phase_mask;
        last_bus_q  <= last_bus_d;
        bus_q       <= 5'd0;
        ptr_q       <= 3'd0;
        timeout_err <= 1'b0;
        err_cnt     <= 8'd0;
      end else if (!abort) begin
        case (state_q)
          S_SELECT: begin
            if (sel_found) begin
              phase_q <= sel_phase;
              tmr_q   <= TMO_LOAD;
            end
          end
          S_REQ: begin
            // A matching end in the timeout cycle counts as a normal end.
            if (end_hit) begin
              ptr_q <= {1'b0, phase_q} + 3'd1;
              tmr_q <= GAP_LOAD;
              ewa_q <= (phase_q == 2'd1);
            end else if (tmr_zero) begin
              ptr_q       <= {1'b0, phase_q} + 3'd1;
              tmr_q       <= GAP_LOAD;
              timeout_err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
              tmr_q <= tmr_q - TMR_W'(1);
            end
          end
          S_GAP: begin
            if (!tmr_zero) tmr_q <= tmr_q - TMR_W'(1);
          end
          S_NEXT_BUS: begin
            if (bus_q != last_bus_q) begin
              bus_q <= bus_q + 5'd1;
              ptr_q <= 3'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign phs.phase_req   = (state_q == S_REQ) ? (4'b0001 << phase_q) : 4'b0000;
  assign phs.bus_id      = bus_q;
  assign phs.cur_phase   = phase_q;
  assign phs.endwait_all = ewa_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule
